// File: rtl/cos_seq_ctrl_if.sv
// Handshake and coefficient-ROM bundle for cos_seq_ctrl.
// The slave modport is the controller view: it receives start/x and ROM
// read data, and drives ready/done/result and the ROM address. The master
// modport is the environment view, which requests computations and serves
// the ROM.
interface cos_seq_ctrl_if;
  logic       start;
  logic [7:0] x;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       ready;
  logic       done;
  logic [7:0] result;

  modport master (
    output start,
    output x,
    output rom_data,
    input  rom_addr,
    input  ready,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  x,
    input  rom_data,
    output rom_addr,
    output ready,
    output done,
    output result
  );
endinterface

// File: rtl/cos_seq_ctrl.sv
// Sequential Taylor-series cosine in unsigned Q0.8.
// Each series term is built from the previous one as
// term * x^2 * (1/(2k-1)) * (1/(2k)). The reciprocals are read from an
// external registered ROM. Terms are alternately subtracted from and added
// to a signed accumulator that starts at 255. The accumulator is clamped to
// 0..255 when the result is published.
module cos_seq_ctrl #(
  parameter int unsigned N_TERMS = 4
) (
  input logic         clk,
  input logic         rst,
  cos_seq_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    SQR,
    MUL_X,
    FETCH_A,
    MUL_A,
    FETCH_B,
    MUL_B,
    ACCUM,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]        x_q;
  logic [7:0]        x2;
  logic [7:0]        term;
  logic [3:0]        k;
  logic signed [9:0] acc;
  logic signed [9:0] acc_upd;
  logic [7:0]        acc_clamped;
  logic [3:0]        rom_addr_q;
  logic [7:0]        result_q;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       prod;
  logic [3:0]        k_x2;
  logic              last_term;

  // k is at most 7 whenever an address is formed, so 2k-1 fits in 4 bits.
  assign k_x2      = {k[2:0], 1'b0};
  assign last_term = (k >= 4'(N_TERMS - 1));

  // Present state as handshake outputs.
  assign bus.ready    = (state == IDLE);
  assign bus.done     = (state == DONE);
  assign bus.rom_addr = rom_addr_q;
  assign bus.result   = result_q;

  // State register; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = SQR;
      SQR:     state_nxt = (N_TERMS > 1) ? MUL_X : DONE;
      MUL_X:   state_nxt = FETCH_A;
      FETCH_A: state_nxt = MUL_A;
      MUL_A:   state_nxt = FETCH_B;
      FETCH_B: state_nxt = MUL_B;
      MUL_B:   state_nxt = ACCUM;
      ACCUM:   state_nxt = last_term ? DONE : MUL_X;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A single 8x8 multiplier is shared by the squaring and the three term
  // scalings. Only the top byte of the product is kept, which truncates.
  always_comb begin
    mul_a = term;
    mul_b = bus.rom_data;
    if (state == SQR) begin
      mul_a = x_q;
      mul_b = x_q;
    end else if (state == MUL_X) begin
      mul_b = x2;
    end
    prod = {8'h00, mul_a} * {8'h00, mul_b};
  end

  // Accumulator update for the current term, and the clamped view of it.
  // The clamped view covers both the SQR->DONE path and the ACCUM->DONE path.
  always_comb begin
    acc_upd = acc;
    if (state == ACCUM) begin
      if (k[0]) acc_upd = acc - $signed({2'b00, term});
      else      acc_upd = acc + $signed({2'b00, term});
    end
    if (acc_upd < 10'sd0)        acc_clamped = '0;
    else if (acc_upd > 10'sd255) acc_clamped = '1;
    else                         acc_clamped = acc_upd[7:0];
  end

  // Datapath registers, sequenced by the controller state.
  // The result is loaded on the edge that enters DONE, so it is already
  // valid during the cycle in which done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      x2         <= '0;
      term       <= '0;
      k          <= '0;
      acc        <= '0;
      rom_addr_q <= '0;
      result_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            x_q  <= bus.x;
            term <= 8'hFF;
            acc  <= 10'sd255;
            k    <= 4'd1;
          end
        end
        SQR: begin
          x2 <= prod[15:8];
        end
        MUL_X: begin
          term       <= prod[15:8];
          rom_addr_q <= k_x2 - 4'd2;
        end
        MUL_A: begin
          term       <= prod[15:8];
          rom_addr_q <= k_x2 - 4'd1;
        end
        MUL_B: begin
          term <= prod[15:8];
        end
        ACCUM: begin
          acc <= acc_upd;
          k   <= k + 4'd1;
        end
        default: ;
      endcase
      if (state != DONE && state_nxt == DONE) result_q <= acc_clamped;
    end
  end

endmodule

// File: tb/tb_cos_seq_ctrl.sv
// Directed and randomized checks of cos_seq_ctrl against a series model.
module tb_cos_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cos_seq_ctrl_if b4();
  cos_seq_ctrl_if b1();

  cos_seq_ctrl #(.N_TERMS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  cos_seq_ctrl #(.N_TERMS(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int nassert = 0;
  int nfail   = 0;
  logic [7:0] last_res4;

  function automatic logic [7:0] rom_val(input logic [3:0] a);
    if (a == 4'd0) return 8'hFF;
    return 8'(256 / (int'(a) + 1));
  endfunction

  // Registered-read coefficient ROMs.
  always @(posedge clk) begin
    b4.rom_data <= rom_val(b4.rom_addr);
    b1.rom_data <= rom_val(b1.rom_addr);
  end

  // Series model: cos(x) = sum over k of (-1)^k x^(2k)/(2k)!, in truncating Q0.8.
  function automatic logic [7:0] ref_cos(input logic [7:0] xv, input int n);
    int xx, t, a;
    xx = (int'(xv) * int'(xv)) / 256;
    t  = 255;
    a  = 255;
    for (int kk = 1; kk < n; kk++) begin
      t = (t * xx) / 256;
      t = (t * int'(rom_val(4'(2 * kk - 2)))) / 256;
      t = (t * int'(rom_val(4'(2 * kk - 1)))) / 256;
      a = (kk % 2 == 1) ? a - t : a + t;
    end
    if (a < 0)   a = 0;
    if (a > 255) a = 255;
    return 8'(a);
  endfunction

  // Expected ROM address after edge e of a 4-term run.
  // Addresses 2k-2 and 2k-1 appear at the entry to the two fetches of term k.
  function automatic logic [3:0] exp_addr(input int e, input logic [3:0] prev);
    logic [3:0] v;
    v = prev;
    for (int kk = 1; kk < 4; kk++) begin
      if (e >= 2 + 6 * (kk - 1)) v = 4'(2 * kk - 2);
      if (e >= 4 + 6 * (kk - 1)) v = 4'(2 * kk - 1);
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 4-term computation.
  // hold keeps start asserted throughout the run; jitter changes x every cycle.
  task automatic run4(input logic [7:0] xv, input bit hold, input bit jitter);
    logic [7:0] exp;
    logic [3:0] a0;
    int w;
    w = 0;
    while (b4.ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 16'(b4.ready), 16'd1);
    exp     = ref_cos(xv, 4);
    a0      = b4.rom_addr;
    b4.x    = xv;
    b4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_low_e0", 16'(b4.ready), 16'd0);
    check("done_low_e0", 16'(b4.done), 16'd0);
    b4.start = hold;
    if (jitter) b4.x = 8'($urandom);
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e <= 19) begin
        check("done_timing", 16'(b4.done), 16'(e == 19));
        check("ready_busy", 16'(b4.ready), 16'd0);
        check("rom_addr", 16'(b4.rom_addr), 16'(exp_addr(e, a0)));
        if (e < 19) check("result_held", 16'(b4.result), 16'(last_res4));
        else        check("result", 16'(b4.result), 16'(exp));
      end else begin
        check("done_pulse_end", 16'(b4.done), 16'd0);
        check("ready_back", 16'(b4.ready), 16'd1);
        check("result_kept", 16'(b4.result), 16'(exp));
      end
      if (jitter) b4.x = 8'($urandom);
    end
    last_res4 = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    b4.start = 1'b0;
    b4.x     = '0;
    b1.start = 1'b0;
    b1.x     = '0;
    repeat (2) @(posedge clk);
    // Reset must win over a simultaneous start.
    @(negedge clk);
    b4.start = 1'b1;
    @(negedge clk);
    check("rst_ready", 16'(b4.ready), 16'd1);
    check("rst_done", 16'(b4.done), 16'd0);
    check("rst_result", 16'(b4.result), 16'd0);
    check("rst_rom_addr", 16'(b4.rom_addr), 16'd0);
    check("rst1_result", 16'(b1.result), 16'd0);
    b4.start = 1'b0;
    rst      = 1'b0;
    last_res4 = 8'h00;

    // Directed angles: zero, one half, and the largest value.
    run4(8'h00, 1'b0, 1'b0);
    check("x00_result", 16'(b4.result), 16'h00FF);
    run4(8'h80, 1'b0, 1'b0);
    check("x80_result", 16'(b4.result), 16'h00E0);
    run4(8'hFF, 1'b0, 1'b0);
    check("xFF_result", 16'(b4.result), 16'h008B);

    // Start held high with x changing: only the accepted x counts.
    run4(8'($urandom), 1'b1, 1'b1);
    run4(8'($urandom), 1'b1, 1'b1);
    b4.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", 16'(b4.ready), 16'd1);
      check("idle_result", 16'(b4.result), 16'(last_res4));
    end

    // Random angles.
    for (int i = 0; i < 8; i++) run4(8'($urandom), 1'b0, 1'b0);

    // Abort with reset at edge 7 of a run.
    b4.x     = 8'h80;
    b4.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", 16'(b4.ready), 16'd1);
    check("abort_done", 16'(b4.done), 16'd0);
    check("abort_result", 16'(b4.result), 16'd0);
    check("abort_rom_addr", 16'(b4.rom_addr), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    last_res4 = 8'h00;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("abort_no_done", 16'(b4.done), 16'd0);
    end
    run4(8'h80, 1'b0, 1'b0);
    check("after_abort", 16'(b4.result), 16'h00E0);

    // Single-term instance: done right after the squaring step.
    @(negedge clk);
    check("n1_ready", 16'(b1.ready), 16'd1);
    b1.x     = 8'hFF;
    b1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.start = 1'b0;
    check("n1_done_e0", 16'(b1.done), 16'd0);
    check("n1_ready_e0", 16'(b1.ready), 16'd0);
    @(negedge clk);
    check("n1_done_e1", 16'(b1.done), 16'd1);
    check("n1_result", 16'(b1.result), 16'(ref_cos(8'hFF, 1)));
    check("n1_rom_addr", 16'(b1.rom_addr), 16'd0);
    @(negedge clk);
    check("n1_done_e2", 16'(b1.done), 16'd0);
    check("n1_ready_e2", 16'(b1.ready), 16'd1);
    check("n1_result_kept", 16'(b1.result), 16'h00FF);
    check("n1_rom_addr_e2", 16'(b1.rom_addr), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
